// File: rtl/boot_stream_loader.sv
// Framed byte-stream program loader: assembles LE words, strobes them into
// the core's IMEM write port and releases the core once the checksum matches.
module boot_stream_loader #(
    parameter logic [7:0]  MAGIC     = 8'hA5,
    parameter int unsigned MAX_WORDS = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        load_en,
    output logic [31:0] load_addr,
    output logic [31:0] load_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ADDR  = 3'd1;
    localparam logic [2:0] COUNT = 3'd2;
    localparam logic [2:0] DATA  = 3'd3;
    localparam logic [2:0] EMIT  = 3'd4;
    localparam logic [2:0] CSUM  = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;
    localparam logic [2:0] ERR   = 3'd7;

    localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

    logic [2:0]  state;
    logic [1:0]  idx;
    logic [31:0] word_cnt;
    logic [31:0] count;
    logic [31:0] base;
    logic [7:0]  csum;
    logic [31:0] shreg;

    logic        xfer;
    logic [31:0] n_next;
    logic [31:0] word_next;

    assign in_ready  = (state != EMIT);
    assign xfer      = in_valid && in_ready;
    // Multi-byte fields arrive LSB first, so shifting in at the top
    // leaves the first byte in lane 0 after four bytes.
    assign n_next    = {in_data, count[31:8]};
    assign word_next = {in_data, shreg[31:8]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= 2'd0;
            word_cnt  <= 32'd0;
            count     <= 32'd0;
            base      <= 32'd0;
            csum      <= 8'd0;
            shreg     <= 32'd0;
            load_en   <= 1'b0;
            load_addr <= 32'd0;
            load_data <= 32'd0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            load_en <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (xfer && in_data == MAGIC) begin
                        state    <= ADDR;
                        idx      <= 2'd0;
                        csum     <= 8'd0;
                        cpu_hold <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                    end
                end
                ADDR: begin
                    if (xfer) begin
                        base <= {in_data, base[31:8]};
                        idx  <= idx + 2'd1;
                        if (idx == 2'd3) state <= COUNT;
                    end
                end
                COUNT: begin
                    if (xfer) begin
                        count <= n_next;
                        idx   <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            if (n_next > MAX_N) begin
                                state <= ERR;
                                err   <= 1'b1;
                            end else if (n_next == 32'd0) begin
                                state <= CSUM;
                            end else begin
                                state    <= DATA;
                                word_cnt <= 32'd0;
                            end
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        shreg <= word_next;
                        csum  <= csum + in_data;
                        idx   <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            state     <= EMIT;
                            load_en   <= 1'b1;
                            load_addr <= base + {word_cnt[29:0], 2'b00};
                            load_data <= word_next;
                        end
                    end
                end
                EMIT: begin
                    word_cnt <= word_cnt + 32'd1;
                    if (word_cnt + 32'd1 == count) state <= CSUM;
                    else                            state <= DATA;
                end
                CSUM: begin
                    if (xfer) begin
                        if (in_data == csum) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_boot_stream_loader.sv
// Directed bench for boot_stream_loader: frames are streamed in, expected
// word writes are queued and checked by an independent load monitor.
module tb_boot_stream_loader;

    localparam logic [7:0] MAGIC = 8'hA5;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    boot_stream_loader #(.MAGIC(MAGIC), .MAX_WORDS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit gaps);
        int waited;
        bit r;
        waited = 0;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                in_data = 8'($urandom);
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        forever begin
            r = in_ready;
            @(posedge clk);
            if (r) break;
            waited++;
            if (waited > 20) begin
                checks++;
                errors++;
                $display("FAIL handshake_timeout: byte %h not accepted", b);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic frame(input logic [31:0] base, input logic [31:0] n,
                         input logic [31:0] w[4], input int nw,
                         input logic [7:0] cs, input bit gaps);
        send(MAGIC, gaps);
        chk("hold_after_magic", {31'd0, cpu_hold}, 32'd1);
        chk("done_clr_after_magic", {31'd0, done}, 32'd0);
        chk("err_clr_after_magic", {31'd0, err}, 32'd0);
        for (int k = 0; k < 4; k++) send(base[8*k +: 8], gaps);
        for (int k = 0; k < 4; k++) send(n[8*k +: 8], gaps);
        for (int i = 0; i < nw; i++)
            for (int k = 0; k < 4; k++) send(w[i][8*k +: 8], gaps);
        send(cs, gaps);
    endtask

    task automatic status(input string name, input logic d, input logic e,
                          input logic h);
        chk({name, "_done"}, {31'd0, done}, {31'd0, d});
        chk({name, "_err"}, {31'd0, err}, {31'd0, e});
        chk({name, "_hold"}, {31'd0, cpu_hold}, {31'd0, h});
    endtask

    // Load monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            checks++;
            if (in_ready !== !load_en) begin
                errors++;
                $display("FAIL ready_vs_emit: in_ready=%b load_en=%b",
                         in_ready, load_en);
            end
            if (load_en === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_load: addr=%h data=%h",
                             load_addr, load_data);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    if ({load_addr, load_data} !== e) begin
                        errors++;
                        $display("FAIL load_word: got %h/%h expected %h/%h",
                                 load_addr, load_data, e[63:32], e[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w[4];
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_load_en", {31'd0, load_en}, 32'd0);
        chk("rst_load_addr", load_addr, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        status("rst", 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Garbage then an empty frame
        w = '{32'd0, 32'd0, 32'd0, 32'd0};
        send(8'h00, 1'b0);
        send(8'hFF, 1'b0);
        status("garbage", 1'b0, 1'b0, 1'b1);
        frame(32'h0000_0010, 32'd0, w, 0, 8'h00, 1'b0);
        status("n0", 1'b1, 1'b0, 1'b0);
        chk("n0_load_addr", load_addr, 32'd0);

        // Nominal two-word frame
        w = '{32'h0000_0013, 32'h0010_0093, 32'd0, 32'd0};
        exp_q.push_back({32'h8000_0000, 32'h0000_0013});
        exp_q.push_back({32'h8000_0004, 32'h0010_0093});
        frame(32'h8000_0000, 32'd2, w, 2, 8'hB6, 1'b0);
        status("nominal", 1'b1, 1'b0, 1'b0);

        // Bad checksum: words still written, core stays held
        exp_q.push_back({32'h8000_0000, 32'h0000_0013});
        exp_q.push_back({32'h8000_0004, 32'h0010_0093});
        frame(32'h8000_0000, 32'd2, w, 2, 8'hB7, 1'b0);
        status("badcsum", 1'b0, 1'b1, 1'b1);

        // Oversize count (limit 4) aborts after the 4th count byte
        send(MAGIC, 1'b0);
        chk("over_err_cleared", {31'd0, err}, 32'd0);
        for (int k = 0; k < 4; k++) send(8'h00, 1'b0);
        send(8'h05, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        chk("over_err_before_last", {31'd0, err}, 32'd0);
        send(8'h00, 1'b0);
        status("oversize", 1'b0, 1'b1, 1'b1);
        send(8'h13, 1'b0);
        status("oversize_idle", 1'b0, 1'b1, 1'b1);
        w = '{32'd0, 32'd0, 32'd0, 32'd0};
        frame(32'h0000_0000, 32'd0, w, 0, 8'h00, 1'b0);
        status("after_over", 1'b1, 1'b0, 1'b0);

        // Count exactly at the limit
        w = '{32'h0403_0201, 32'h0807_0605, 32'h0C0B_0A09, 32'h100F_0E0D};
        exp_q.push_back({32'h0000_0100, 32'h0403_0201});
        exp_q.push_back({32'h0000_0104, 32'h0807_0605});
        exp_q.push_back({32'h0000_0108, 32'h0C0B_0A09});
        exp_q.push_back({32'h0000_010C, 32'h100F_0E0D});
        frame(32'h0000_0100, 32'd4, w, 4, 8'h88, 1'b0);
        status("max_n", 1'b1, 1'b0, 1'b0);

        // Gapped valid with address wrap
        w = '{32'h0000_0013, 32'h0010_0093, 32'd0, 32'd0};
        exp_q.push_back({32'hFFFF_FFFC, 32'h0000_0013});
        exp_q.push_back({32'h0000_0000, 32'h0010_0093});
        frame(32'hFFFF_FFFC, 32'd2, w, 2, 8'hB6, 1'b1);
        status("wrap", 1'b1, 1'b0, 1'b0);

        // Reset after two data bytes
        send(MAGIC, 1'b0);
        send(8'h00, 1'b0);
        send(8'h02, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h01, 1'b0);
        for (int k = 0; k < 3; k++) send(8'h00, 1'b0);
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        rst = 1'b0;
        #1;
        status("midrst", 1'b0, 1'b0, 1'b1);
        chk("midrst_load_en", {31'd0, load_en}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_load_addr", load_addr, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        w = '{32'h1234_5678, 32'd0, 32'd0, 32'd0};
        exp_q.push_back({32'h0000_0200, 32'h1234_5678});
        frame(32'h0000_0200, 32'd1, w, 1, 8'h14, 1'b0);
        status("post_rst", 1'b1, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        chk("pending_loads", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/boot_stream_loader.md
Name: boot_stream_loader

Overview:
- Upstream program-load front end for the single-cycle core.
- Receives a framed byte stream over a valid/ready handshake (e.g. from UART RX).
- Assembles little-endian 32-bit words and drives the core's word-load interface (load_en / load_addr / load_data).
- Holds the core in reset until a frame loads cleanly, then releases it.

Parameters:
- MAGIC, 8'hA5, frame start byte.
- MAX_WORDS, 65536, largest accepted word count; a larger count is a frame error.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  byte available on in_data
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle; transfer occurs when in_valid && in_ready at the clk rising edge
- load_en  out  1  one-cycle word write strobe to the core
- load_addr  out  32  byte address of the word
- load_data  out  32  assembled word
- cpu_hold  out  1  core reset request; 1 = core held
- done  out  1  last frame loaded and checksum matched
- err  out  1  last frame aborted

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; byte index, word counter, address, checksum and shift register = 0.
  - Outputs: in_ready = 1, load_en = 0, load_addr = 0, load_data = 0, cpu_hold = 1, done = 0, err = 0.
  - Reset mid-frame discards the partial frame. Words already strobed stay written in IMEM.
- Frame format:
  - MAGIC.
  - 4-byte base address, LSB first.
  - 4-byte word count N, LSB first.
  - 4·N data bytes, each word LSB first.
  - 1 checksum byte = sum of all data bytes mod 256. Header bytes are excluded.
- States: IDLE, ADDR, COUNT, DATA, EMIT, CSUM, DONE, ERR.
- IDLE:
  - Non-MAGIC bytes are consumed and ignored.
  - MAGIC → ADDR; clear the checksum; cpu_hold = 1; done = err = 0.
- ADDR: accept 4 bytes into the base address → COUNT.
- COUNT: accept 4 bytes into N. After the 4th byte:
  - N > MAX_WORDS → ERR.
  - N == 0 → CSUM.
  - Otherwise → DATA.
- DATA:
  - Each accepted byte shifts into word byte lane [8·k+7:8·k] (k = 0..3) and adds to the checksum (8-bit wrap).
  - The 4th byte → EMIT.
- EMIT (exactly 1 cycle):
  - in_ready = 0; load_en = 1; load_addr = base + 4·i; load_data = assembled word. Address arithmetic wraps mod 2^32.
  - Next cycle: i++. If i == N → CSUM, else → DATA.
  - load_en is high only in EMIT. load_addr / load_data hold their last values otherwise.
- CSUM:
  - Accept 1 byte. Match → DONE (done = 1, cpu_hold = 0).
  - Mismatch → ERR (err = 1, cpu_hold stays 1).
- DONE / ERR:
  - in_ready = 1. Non-MAGIC bytes are ignored.
  - MAGIC starts a new frame exactly as from IDLE: clears done/err, raises cpu_hold the cycle after acceptance.
- Handshake:
  - in_ready is a function of state only, not of in_valid.
  - Sustained throughput is 4 bytes per 5 cycles in DATA.
  - A byte with in_valid low is never consumed, and state does not advance.
- cpu_hold: registered. It changes the cycle after the causing transfer. done and err are never both 1.

Test Plan:
- Nominal frame:
  - Stream A5 00 00 00 80 02 00 00 00 13 00 00 00 93 00 10 00 B6 with in_valid held high.
  - Required: load_en pulse with 0x80000000 / 0x00000013, then 0x80000004 / 0x00100093.
  - Then done = 1, cpu_hold = 0, err = 0.
  - in_ready = 0 exactly in the two EMIT cycles.
- Bad checksum:
  - Same frame with final byte B7.
  - Required: both load_en pulses still occur; err = 1, done = 0, cpu_hold = 1.
- Garbage and N = 0:
  - Stream 00 FF A5 10 00 00 00 00 00 00 00 00.
  - Required: leading bytes ignored; no load_en; done = 1; load_addr stays 0.
- Oversize count:
  - With MAX_WORDS = 4, send count 5.
  - Required: err = 1 after the 4th count byte; no load_en; later MAGIC clears err.
- Gapped valid / wrap:
  - Base 0xFFFFFFFC, N = 2, random in_valid gaps.
  - Required: addresses 0xFFFFFFFC then 0x00000000; data identical to the gapless run.
- Reset mid-DATA:
  - Drop rst low after 2 data bytes.
  - Required: immediate IDLE, cpu_hold = 1, load_en = 0.
  - The next full frame loads correctly from byte 0.
